// File: rtl/mini_core_accel_pkg.sv
// mini_core_accel_pkg: CR map, lane FSM states and operand/result types for the accelerator farm
package mini_core_accel_pkg;
  localparam int INT8_MULTIPLIER_NUM = 16;
  localparam int NUM_WIDTH_INT8 = 8;
  localparam logic [31:0] CR_MEM_REGION_FLOOR = 32'h00FE_F000;
  localparam logic [31:0] CR_MEM_REGION_ROOF = 32'h00FE_FFFF;
  localparam logic [31:0] CR_MULTIPLICANT_0 = 32'h00FE_F000;
  localparam logic [31:0] CR_MULTIPLIER_0 = 32'h00FE_F001;
  localparam logic [31:0] CR_MUL2CORE_INT8_0 = 32'h00FE_F050;
  localparam logic [31:0] CR_DONE_0 = 32'h00FE_F051;
  localparam logic [31:0] CR_DEBUG_0 = 32'h00FE_FF00;
  // Low-half offsets; the window check pins the upper half, so decode compares only these
  localparam logic [15:0] CR_MULT_OFF = 16'hF000;
  localparam logic [15:0] CR_RES_OFF = 16'hF050;
  localparam logic [15:0] CR_DEBUG_OFF = 16'hFF00;
  localparam int CR_STRIDE = 2;
  typedef enum logic [1:0] {PRE_START, COMPUTE, DONE} t_mul_int8_states;
  typedef struct packed {
    logic [NUM_WIDTH_INT8-1:0] multiplicant;
    logic [NUM_WIDTH_INT8-1:0] multiplier;
  } t_cr_int8_multiplier;
  typedef struct packed {
    logic start;
    logic abort;
    t_cr_int8_multiplier ops;
  } t_mul_int8_input;
  typedef struct packed {
    logic [2*NUM_WIDTH_INT8-1:0] result;
    logic done;
    logic busy;
  } t_mul_int8_output;
  typedef t_mul_int8_input [INT8_MULTIPLIER_NUM-1:0] t_accel_farm_input;
  typedef t_mul_int8_output [INT8_MULTIPLIER_NUM-1:0] t_accel_farm_output;
  typedef logic [31:0] t_cr_debug;
endpackage

// File: rtl/mini_core_accel_cr_farm_if.sv
// mini_core_accel_cr_farm_if: core->accelerator CR access bus
interface mini_core_accel_cr_farm_if
  import mini_core_accel_pkg::*;
#(parameter int MUL_NUM = INT8_MULTIPLIER_NUM);
  logic cr_wr_en;
  logic cr_rd_en;
  logic [31:0] cr_address;
  logic [31:0] cr_wr_data;
  logic [31:0] cr_rd_data;
  logic [MUL_NUM-1:0] mul_busy;
  modport master (output cr_wr_en, cr_rd_en, cr_address, cr_wr_data, input cr_rd_data, mul_busy);
  modport slave (input cr_wr_en, cr_rd_en, cr_address, cr_wr_data, output cr_rd_data, mul_busy);
endinterface

// File: rtl/mini_core_accel_mul_int8_seq.sv
// mini_core_accel_mul_int8_seq: one unsigned 8x8 shift-add lane, one multiplier bit per cycle
module mini_core_accel_mul_int8_seq
  import mini_core_accel_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  t_mul_int8_input  lane_in,
  output t_mul_int8_output lane_out
);
  t_mul_int8_states state;
  t_cr_int8_multiplier ops;
  logic [2:0] cnt;
  logic [2*NUM_WIDTH_INT8-1:0] acc, term;
  assign term = ops.multiplier[cnt] ? (2*NUM_WIDTH_INT8)'(ops.multiplicant) << cnt : '0;
  // start outranks everything so a rewrite mid-COMPUTE can never publish the stale product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PRE_START;
      ops <= '0;
      cnt <= '0;
      acc <= '0;
      lane_out <= '0;
    end else if (lane_in.start) begin
      state <= COMPUTE;
      ops <= lane_in.ops;
      cnt <= '0;
      acc <= '0;
      lane_out.done <= 1'b0;
      lane_out.busy <= 1'b1;
    end else begin
      if (state == COMPUTE) begin
        acc <= acc + term;
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          state <= DONE;
          lane_out.result <= acc + term;
          lane_out.done <= 1'b1;
          lane_out.busy <= 1'b0;
        end
      end
      if (lane_in.abort) lane_out.done <= 1'b0;
    end
  end
endmodule

// File: rtl/mini_core_accel_cr_farm.sv
// mini_core_accel_cr_farm: CR decode, operand/debug registers and read mux in front of the multiplier lanes
module mini_core_accel_cr_farm
  import mini_core_accel_pkg::*;
#(
  parameter int MUL_NUM = INT8_MULTIPLIER_NUM,
  parameter int OP_WIDTH = NUM_WIDTH_INT8
)
(
  input logic clk,
  input logic rst,
  mini_core_accel_cr_farm_if.slave cr
);
  t_cr_int8_multiplier ops [MUL_NUM];
  t_mul_int8_output lane_out [MUL_NUM];
  t_cr_debug cr_debug_0;
  logic [MUL_NUM-1:0] wr_a, wr_b, start, busy;
  logic [31:0] rd_mux;
  logic [15:0] off;
  logic in_win, wr_dbg;
  assign in_win = cr.cr_address >= CR_MEM_REGION_FLOOR && cr.cr_address <= CR_MEM_REGION_ROOF;
  assign off = cr.cr_address[15:0];
  assign wr_dbg = cr.cr_wr_en && in_win && off == CR_DEBUG_OFF;
  always_comb begin
    wr_a = '0;
    wr_b = '0;
    rd_mux = (in_win && off == CR_DEBUG_OFF) ? cr_debug_0 : '0;
    for (int i = 0; i < MUL_NUM; i++) begin
      wr_a[i] = cr.cr_wr_en && in_win && off == CR_MULT_OFF + 16'(CR_STRIDE*i);
      wr_b[i] = cr.cr_wr_en && in_win && off == CR_MULT_OFF + 16'(CR_STRIDE*i + 1);
      if (in_win && off == CR_RES_OFF + 16'(CR_STRIDE*i)) rd_mux = {16'b0, lane_out[i].result};
      if (in_win && off == CR_RES_OFF + 16'(CR_STRIDE*i + 1)) rd_mux = {31'b0, lane_out[i].done};
    end
  end
  // a multiplicand write to a busy lane also restarts it so the running product never mixes operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MUL_NUM; i++) ops[i] <= '0;
      start <= '0;
      cr_debug_0 <= '0;
      cr.cr_rd_data <= '0;
    end else begin
      for (int i = 0; i < MUL_NUM; i++) begin
        if (wr_a[i]) ops[i].multiplicant <= cr.cr_wr_data[OP_WIDTH-1:0];
        if (wr_b[i]) ops[i].multiplier <= cr.cr_wr_data[OP_WIDTH-1:0];
      end
      start <= wr_b | (wr_a & busy);
      if (wr_dbg) cr_debug_0 <= cr.cr_wr_data;
      if (cr.cr_rd_en) cr.cr_rd_data <= rd_mux;
    end
  end
  for (genvar g = 0; g < MUL_NUM; g++) begin : g_lane
    mini_core_accel_mul_int8_seq u_lane (
      .clk(clk),
      .rst(rst),
      .lane_in('{start: start[g], abort: wr_a[g] | wr_b[g], ops: ops[g]}),
      .lane_out(lane_out[g])
    );
    assign busy[g] = lane_out[g].busy;
  end
  assign cr.mul_busy = busy;
endmodule

// File: tb/tb_mini_core_accel_cr_farm.sv
// tb_mini_core_accel_cr_farm: directed CR accesses with a read scoreboard against the accelerator farm
module tb_mini_core_accel_cr_farm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int miss = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];
  mini_core_accel_cr_farm_if bus ();
  mini_core_accel_cr_farm dut (.clk(clk), .rst(rst), .cr(bus));
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] e);
    vecs++;
    assert (got === e) else begin
      miss++;
      $error("FAIL %s got=%h exp=%h", t, got, e);
    end
  endtask
  task automatic pop_chk();
    if (exp_q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
    else chk(tag_q.pop_front(), bus.cr_rd_data, exp_q.pop_front());
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string t);
    @(negedge clk);
    exp_q.push_back(e);
    tag_q.push_back(t);
    bus.cr_rd_en = 1'b1;
    bus.cr_address = a;
    @(negedge clk);
    bus.cr_rd_en = 1'b0;
    pop_chk();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cr_wr_en = 1'b1;
    bus.cr_address = a;
    bus.cr_wr_data = d;
    @(negedge clk);
    bus.cr_wr_en = 1'b0;
  endtask
  // entered just after the multiplier write edge T; read sampled at T+k sees done set by T+k-1
  task automatic poll_done(input int l, input string t);
    bus.cr_rd_en = 1'b1;
    bus.cr_address = 32'h00FE_F051 + 32'(2*l);
    for (int k = 1; k <= 10; k++) begin
      exp_q.push_back(k >= 10 ? 32'd1 : 32'd0);
      tag_q.push_back(t);
      @(negedge clk);
      pop_chk();
      chk({t, "_busy"}, 32'(bus.mul_busy[l]), k <= 8 ? 32'd1 : 32'd0);
    end
    bus.cr_rd_en = 1'b0;
  endtask
  initial begin
    logic [15:0] m;
    bus.cr_wr_en = 1'b0;
    bus.cr_rd_en = 1'b0;
    bus.cr_address = '0;
    bus.cr_wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", 32'(bus.mul_busy), 32'd0);
    chk("reset_rd_data", bus.cr_rd_data, 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(32'h00FE_F050 + 32'(2*i), 32'd0, "reset_result");
      rd(32'h00FE_F051 + 32'(2*i), 32'd0, "reset_done");
    end
    rd(32'h00FE_FF00, 32'd0, "reset_debug");
    @(negedge clk);
    bus.cr_wr_en = 1'b1;
    bus.cr_rd_en = 1'b1;
    bus.cr_address = 32'h00FE_FF00;
    bus.cr_wr_data = 32'hDEAD_BEEF;
    exp_q.push_back(32'd0);
    tag_q.push_back("debug_rw_same_cycle");
    @(negedge clk);
    bus.cr_wr_en = 1'b0;
    bus.cr_rd_en = 1'b0;
    pop_chk();
    rd(32'h00FE_FF00, 32'hDEAD_BEEF, "debug_readback");
    repeat (2) @(negedge clk);
    chk("rd_data_hold", bus.cr_rd_data, 32'hDEAD_BEEF);
    wr(32'h00FE_F000, 32'h07);
    wr(32'h00FE_F001, 32'h06);
    poll_done(0, "lane0_done");
    rd(32'h00FE_F050, 32'h0000_002A, "lane0_result");
    rd(32'h00FE_F051, 32'd1, "lane0_done_sticky");
    wr(32'h00FE_F01E, 32'hFF);
    wr(32'h00FE_F01F, 32'hFF);
    repeat (10) @(negedge clk);
    rd(32'h00FE_F06E, 32'h0000_FE01, "lane15_max");
    rd(32'h00FE_F06F, 32'd1, "lane15_done");
    for (int i = 0; i < 16; i++) wr(32'h00FE_F000 + 32'(2*i), 32'(i));
    rd(32'h00FE_F06F, 32'd0, "mcand_clears_done");
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      m = '0;
      for (int j = 0; j < 16; j++) if (j >= i - 9 && j <= i - 2) m[j] = 1'b1;
      chk("busy_seq", 32'(bus.mul_busy), 32'(m));
      bus.cr_wr_en = 1'b1;
      bus.cr_address = 32'h00FE_F001 + 32'(2*i);
      bus.cr_wr_data = 32'(i + 3);
    end
    @(negedge clk);
    bus.cr_wr_en = 1'b0;
    repeat (12) @(negedge clk);
    chk("all_idle", 32'(bus.mul_busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      rd(32'h00FE_F050 + 32'(2*i), 32'(i*(i+3)), "farm_result");
      rd(32'h00FE_F051 + 32'(2*i), 32'd1, "farm_done");
    end
    wr(32'h00FE_F052, 32'h0);
    rd(32'h00FE_F052, 32'd4, "ro_result_write");
    wr(32'h00FF_F003, 32'h55);
    wr(32'h00FE_F100, 32'h1234);
    repeat (10) @(negedge clk);
    rd(32'h00FE_F053, 32'd1, "oow_write_done");
    rd(32'h00FE_F052, 32'd4, "oow_write_result");
    rd(32'h00FE_F100, 32'd0, "unmapped_read");
    wr(32'h00FF_0000, 32'hFFFF_FFFF);
    rd(32'h00FF_FF00, 32'd0, "oow_read");
    rd(32'h00FE_FF00, 32'hDEAD_BEEF, "debug_untouched");
    wr(32'h00FE_F006, 32'h10);
    wr(32'h00FE_F007, 32'h05);
    repeat (2) @(negedge clk);
    wr(32'h00FE_F007, 32'h02);
    poll_done(3, "lane3_restart_done");
    rd(32'h00FE_F056, 32'h0000_0020, "lane3_restart_result");
    wr(32'h00FE_F004, 32'h09);
    wr(32'h00FE_F005, 32'h09);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset_busy", 32'(bus.mul_busy), 32'd0);
    repeat (10) @(negedge clk);
    rd(32'h00FE_F055, 32'd0, "midrun_reset_done");
    rd(32'h00FE_F054, 32'd0, "midrun_reset_result");
    rd(32'h00FE_FF00, 32'd0, "midrun_reset_debug");
    wr(32'h00FE_F004, 32'h03);
    wr(32'h00FE_F005, 32'h04);
    repeat (10) @(negedge clk);
    rd(32'h00FE_F054, 32'd12, "post_reset_result");
    rd(32'h00FE_F055, 32'd1, "post_reset_done");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
